// File: rtl/btn_event_pkg.sv
// Shared types and defaults for button_event_unit.
// Optional auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
package btn_event_pkg;

  typedef enum logic [2:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    LONG_HELD,
    RELEASE_WAIT
  } btn_state_t;

  // Defaults assume a 100 MHz clock.
  localparam int DEF_N_CH        = 5;
  localparam int DEF_DB_CYCLES   = 1_000_000;    // 10 ms
  localparam int DEF_LONG_CYCLES = 100_000_000;  // 1 s
  localparam int DEF_REP_CYCLES  = 20_000_000;   // 200 ms

  // Counter width for a count range of 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_event_channel.sv
// One button channel: 2-flop synchroniser, debounce/hold FSM and its counters.
// Auto-repeat output and counter exist only when BTN_AUTOREPEAT_EN is defined;
// otherwise repeat_o is tied low and REP_CYCLES has no effect.
//
// Handshake: none. Pulses (press/release/long/repeat) are single-cycle,
// registered, and carry no backpressure; consumers must sample every cycle.
module btn_event_channel
  import btn_event_pkg::*;
#(
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       btn_i,
  output logic       level_o,
  output logic       press_o,
  output logic       release_o,
  output logic       long_o,
  output logic       repeat_o,
  output btn_state_t state_o
);

  localparam int DB_W   = cnt_w(DB_CYCLES);
  localparam int HOLD_W = cnt_w(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [1:0]        sync_ff;
  logic              sync_btn;
  btn_state_t        state;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_next;
  logic              long_seen;

`ifdef BTN_AUTOREPEAT_EN
  localparam int REP_W = cnt_w(REP_CYCLES);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REP_CYCLES - 1);
  logic [REP_W-1:0] rep_cnt;
`else
  assign repeat_o = 1'b0;
`endif

  assign sync_btn = sync_ff[1];
  assign state_o  = state;
  // Hold time saturates so long_o can only be reached once per press.
  assign hold_next = (hold_cnt == HOLD_LAST) ? hold_cnt : hold_cnt + 1'b1;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) sync_ff <= 2'b00;
    else          sync_ff <= {sync_ff[0], btn_i};
  end

  // Debounce/hold FSM; a release glitch never aborts hold timing or repeat phase.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= RELEASED;
      db_cnt    <= '0;
      hold_cnt  <= '0;
      long_seen <= 1'b0;
      level_o   <= 1'b0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep_cnt   <= '0;
      repeat_o  <= 1'b0;
`endif
    end else begin
      press_o   <= 1'b0;
      release_o <= 1'b0;
      long_o    <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_o  <= 1'b0;
`endif
      case (state)
        RELEASED: begin
          if (sync_btn) begin
            state  <= PRESS_WAIT;
            db_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync_btn) begin
            state <= RELEASED;
          end else if (db_cnt == DB_LAST) begin
            state     <= PRESSED;
            level_o   <= 1'b1;
            press_o   <= 1'b1;
            hold_cnt  <= '0;
            long_seen <= 1'b0;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        PRESSED: begin
          hold_cnt <= hold_next;
          // A low sample wins so release latency stays fixed.
          if (!sync_btn) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state     <= LONG_HELD;
            long_o    <= 1'b1;
            long_seen <= 1'b1;
`ifdef BTN_AUTOREPEAT_EN
            rep_cnt   <= '0;
`endif
          end
        end
        LONG_HELD: begin
          if (!sync_btn) begin
            state  <= RELEASE_WAIT;
            db_cnt <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (rep_cnt == REP_LAST) begin
            rep_cnt  <= '0;
            repeat_o <= 1'b1;
          end else begin
            rep_cnt <= rep_cnt + 1'b1;
          end
`endif
        end
        RELEASE_WAIT: begin
          hold_cnt <= hold_next;
          if (sync_btn) begin
            state <= long_seen ? LONG_HELD : PRESSED;
          end else if (db_cnt == DB_LAST) begin
            state     <= RELEASED;
            level_o   <= 1'b0;
            release_o <= 1'b1;
          end else begin
            db_cnt <= db_cnt + 1'b1;
          end
        end
        default: state <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/button_event_unit.sv
// N_CH independent debounced buttons with press/release/long/repeat pulses.
// Auto-repeat is enabled by defining BTN_AUTOREPEAT_EN.
module button_event_unit
  import btn_event_pkg::*;
#(
  parameter int N_CH        = DEF_N_CH,
  parameter int DB_CYCLES   = DEF_DB_CYCLES,
  parameter int LONG_CYCLES = DEF_LONG_CYCLES,
  parameter int REP_CYCLES  = DEF_REP_CYCLES
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] long_o,
  output logic [N_CH-1:0] repeat_o
);

  // Per-channel FSM state, available for hierarchical probes.
  btn_state_t dbg_state_unused [N_CH];

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_event_channel #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES),
      .REP_CYCLES (REP_CYCLES)
    ) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .btn_i    (btn_i[i]),
      .level_o  (level_o[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .long_o   (long_o[i]),
      .repeat_o (repeat_o[i]),
      .state_o  (dbg_state_unused[i])
    );
  end

endmodule

// File: tb/tb_button_event_unit.sv
// Self-checking bench for button_event_unit (N_CH=2, DB=4, LONG=16, REP=8).
// Reference model works on the sampled input history: a level flips after
// DB+1 consecutive disagreeing samples, long fires LONG edges after press,
// repeats fire every REP held edges after long.
module tb_button_event_unit;

  localparam int N_CH = 2;
  localparam int DB   = 4;
  localparam int LONG = 16;
  localparam int REP  = 8;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N_CH-1:0] btn = '0;
  logic [N_CH-1:0] level_o, press_o, release_o, long_o, repeat_o;

  int checks = 0;
  int passed = 0;

  // Reference model state
  logic [N_CH-1:0] h1 = '0, h2 = '0;
  logic [N_CH-1:0] m_level = '0, m_press = '0, m_release = '0, m_long = '0, m_repeat = '0;
  int run [N_CH];
  int held [N_CH];
  int press_cyc [N_CH];
  bit long_seen [N_CH];
  int cyc = 0;

  button_event_unit #(
    .N_CH(N_CH), .DB_CYCLES(DB), .LONG_CYCLES(LONG), .REP_CYCLES(REP)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .btn_i(btn),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .long_o(long_o), .repeat_o(repeat_o)
  );

  // Clock
  always #5 clk = ~clk;

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    m_press = '0; m_release = '0; m_long = '0; m_repeat = '0;
    if (!rst_n) begin
      h1 = '0; h2 = '0; m_level = '0; cyc = 0;
      for (int ch = 0; ch < N_CH; ch++) begin
        run[ch] = 0; held[ch] = 0; press_cyc[ch] = 0; long_seen[ch] = 1'b0;
      end
      return;
    end
    cyc++;
    for (int ch = 0; ch < N_CH; ch++) begin
      logic s;
      bit   in_hold;
      s = h2[ch];
      h2[ch] = h1[ch];
      h1[ch] = btn[ch];
      in_hold = m_level[ch] && (run[ch] == 0);
      if (s != m_level[ch]) run[ch]++;
      else                  run[ch] = 0;
      if (run[ch] == DB + 1) begin
        run[ch] = 0;
        m_level[ch] = ~m_level[ch];
        if (m_level[ch]) begin
          m_press[ch] = 1'b1;
          press_cyc[ch] = cyc;
          long_seen[ch] = 1'b0;
        end else begin
          m_release[ch] = 1'b1;
        end
      end else if (in_hold && s) begin
        if (!long_seen[ch]) begin
          if (cyc - press_cyc[ch] >= LONG) begin
            m_long[ch] = 1'b1;
            long_seen[ch] = 1'b1;
            held[ch] = 0;
          end
        end else begin
          held[ch]++;
`ifdef BTN_AUTOREPEAT_EN
          if (held[ch] % REP == 0) m_repeat[ch] = 1'b1;
`endif
        end
      end
    end
  endtask

  // One clock: model, edge, then settle away from the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    btn = '0;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    int press_edge;
    rst_n = 1'b0;
    btn = 2'b01;
    repeat (3) tick();
    checks++;
    if ({level_o, press_o, release_o, long_o, repeat_o} !== 10'b0)
      $display("FAIL reset_outputs got %b exp %b", {level_o, press_o, release_o, long_o, repeat_o}, 10'b0);
    else passed++;
    rst_n = 1'b1;
    press_edge = -1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL reset_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (press_o[0] && press_edge < 0) press_edge = e;
    end
    checks++;
    if (press_edge !== 7) $display("FAIL reset_press_latency got %0d exp 7", press_edge);
    else passed++;
    settle();
  endtask

  task automatic test_bounce();
    bit seen = 1'b0;
    for (int e = 1; e <= 13; e++) begin
      btn = (e <= 3) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL bounce_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (press_o[0] || level_o[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) $display("FAIL bounce_no_press got %0d exp 0", seen);
    else passed++;
    settle();
  endtask

  task automatic test_press_hold_release();
    int press_edge = -1, long_edge = -1, rel_edge = -1;
    logic lvl_at_press = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      btn = (e <= 40) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL phr_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (press_o[0] && press_edge < 0) begin press_edge = e; lvl_at_press = level_o[0]; end
      if (long_o[0] && long_edge < 0) long_edge = e;
      if (release_o[0] && rel_edge < 0) rel_edge = e;
    end
    checks++;
    if (press_edge !== 7) $display("FAIL phr_press_edge got %0d exp 7", press_edge); else passed++;
    checks++;
    if (lvl_at_press !== 1'b1) $display("FAIL phr_level_high got %b exp 1", lvl_at_press); else passed++;
    checks++;
    if (long_edge !== 23) $display("FAIL phr_long_edge got %0d exp 23", long_edge); else passed++;
    checks++;
    if (rel_edge !== 47) $display("FAIL phr_release_edge got %0d exp 47", rel_edge); else passed++;
    checks++;
    if (level_o !== 2'b00) $display("FAIL phr_level_low got %b exp 00", level_o); else passed++;
    settle();
  endtask

  task automatic test_glitch();
    int presses = 0, early_rel = 0, long_edge = -1, rel_edge = -1;
    for (int e = 1; e <= 50; e++) begin
      btn = ((e <= 40) && !(e == 10 || e == 11)) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL glitch_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (press_o[0]) presses++;
      if (release_o[0] && e <= 41) early_rel++;
      if (release_o[0] && rel_edge < 0) rel_edge = e;
      if (long_o[0] && long_edge < 0) long_edge = e;
    end
    checks++;
    if (presses !== 1) $display("FAIL glitch_press_count got %0d exp 1", presses); else passed++;
    checks++;
    if (early_rel !== 0) $display("FAIL glitch_no_release got %0d exp 0", early_rel); else passed++;
    checks++;
    if (long_edge !== 23) $display("FAIL glitch_long_edge got %0d exp 23", long_edge); else passed++;
    checks++;
    if (rel_edge !== 47) $display("FAIL glitch_release_edge got %0d exp 47", rel_edge); else passed++;
    settle();
  endtask

  task automatic test_autorepeat();
    int rep_q[$];
    int exp_q[$];
    int rel_edge = -1;
`ifdef BTN_AUTOREPEAT_EN
    exp_q = '{31, 39, 47};
`endif
    for (int e = 1; e <= 70; e++) begin
      btn = (e <= 50) ? 2'b01 : 2'b00;
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL rep_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (repeat_o[0]) rep_q.push_back(e);
      if (release_o[0] && rel_edge < 0) rel_edge = e;
    end
    checks++;
    if (rep_q.size() !== exp_q.size())
      $display("FAIL rep_count got %0d exp %0d", rep_q.size(), exp_q.size());
    else passed++;
    for (int i = 0; i < exp_q.size() && i < rep_q.size(); i++) begin
      checks++;
      if (rep_q[i] !== exp_q[i]) $display("FAIL rep_edge[%0d] got %0d exp %0d", i, rep_q[i], exp_q[i]);
      else passed++;
    end
    checks++;
    if (rel_edge !== 57) $display("FAIL rep_release_edge got %0d exp 57", rel_edge); else passed++;
    settle();
  endtask

  task automatic test_simultaneous();
    for (int e = 1; e <= 30; e++) begin
      btn = (e <= 12) ? 2'b11 : 2'b01;
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL simul_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (e == 7) begin
        checks++;
        if (press_o !== 2'b11) $display("FAIL simul_press got %b exp 11", press_o); else passed++;
      end
      if (e == 19) begin
        checks++;
        if (release_o !== 2'b10) $display("FAIL simul_release got %b exp 10", release_o); else passed++;
        checks++;
        if (level_o !== 2'b01) $display("FAIL simul_level got %b exp 01", level_o); else passed++;
      end
    end
    settle();
  endtask

  task automatic test_reset_mid();
    int press_edge = -1;
    btn = 2'b01;
    repeat (10) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    checks++;
    if ({level_o, press_o, release_o, long_o, repeat_o} !== 10'b0)
      $display("FAIL midreset_outputs got %b exp %b", {level_o, press_o, release_o, long_o, repeat_o}, 10'b0);
    else passed++;
    rst_n = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checks++;
      if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
        $display("FAIL midreset_model e=%0d got %b exp %b", e, {level_o, press_o, release_o, long_o, repeat_o},
                 {m_level, m_press, m_release, m_long, m_repeat});
      else passed++;
      if (press_o[0] && press_edge < 0) press_edge = e;
    end
    checks++;
    if (press_edge !== 7) $display("FAIL midreset_press_latency got %0d exp 7", press_edge); else passed++;
    settle();
  endtask

  task automatic test_random();
    for (int seg = 0; seg < 40; seg++) begin
      int dur;
      btn = 2'($urandom_range(0, 3));
      dur = $urandom_range(1, 30);
      rst_n = ($urandom_range(0, 15) == 0) ? 1'b0 : 1'b1;
      for (int c = 0; c < dur; c++) begin
        tick();
        rst_n = 1'b1;
        checks++;
        if ({level_o, press_o, release_o, long_o, repeat_o} !== {m_level, m_press, m_release, m_long, m_repeat})
          $display("FAIL random_model seg=%0d c=%0d got %b exp %b", seg, c,
                   {level_o, press_o, release_o, long_o, repeat_o},
                   {m_level, m_press, m_release, m_long, m_repeat});
        else passed++;
      end
    end
    settle();
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_press_hold_release();
    test_glitch();
    test_autorepeat();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
